// File: rtl/cpu_lsu.sv
// Load/store unit: one access per handshake, valid/ready data bus with byte strobes, load alignment/extension.
// Optional CPU_LSU_SPLIT_EN: boundary-crossing misaligned accesses become two bus beats instead of faulting.
module cpu_lsu #(
  parameter int XLEN    = 32,
  parameter int NBYTES  = XLEN/8,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [NBYTES-1:0] mem_write,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [XLEN-1:0]   resp_data,
  output logic              fault,
  output logic              busy
);
  localparam int OFFW = $clog2(NBYTES);
`ifdef CPU_LSU_SPLIT_EN
  localparam int LW = 2;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, REQ2, WAIT2} state_t;
`else
  localparam int LW = 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
`endif

  typedef struct packed {
    logic            store;
    logic [1:0]      size;
    logic            uns;
    logic [OFFW-1:0] off;
  } req_t;

  state_t state, state_n;
  req_t   r;
  logic [15:0]          wd_cnt;
  logic [XLEN-1:0]      mem_addr_q, mem_wdata_q, resp_data_q;
  logic [NBYTES-1:0]    mem_write_q;
  logic [4:0]           resp_rd_q;
  logic                 fault_q;

  logic [OFFW-1:0]      in_off;
  logic [LW*NBYTES-1:0] strb_w;
  logic [LW*XLEN-1:0]   wdata_w, merged;
  logic [XLEN-1:0]      field;
  logic [2:0]           amask;
  logic                 mis, illegal, bad, in_req, in_wait, last, wd_hit;
  logic                 accept, abort, done_beat, capture;

`ifdef CPU_LSU_SPLIT_EN
  logic [NBYTES-1:0] hi_strb_q;
  logic [XLEN-1:0]   hi_wdata_q, lo_q;
  logic              split_q, hi_phase, capture_lo;
  assign hi_phase   = (state == REQ2) || (state == WAIT2);
  assign in_req     = (state == REQ)  || (state == REQ2);
  assign in_wait    = (state == WAIT) || (state == WAIT2);
  assign last       = hi_phase || !split_q;
  assign bad        = illegal;
  assign capture_lo = done_beat && !last && !r.store;
`else
  assign in_req  = (state == REQ);
  assign in_wait = (state == WAIT);
  assign last    = 1'b1;
  assign bad     = illegal || mis;
`endif

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [1:0] sz,
                                             input logic uns);
    logic [XLEN-1:0] x;
    case (sz)
      2'd0:    x = uns ? XLEN'(v[7:0])  : XLEN'($signed(v[7:0]));
      2'd1:    x = uns ? XLEN'(v[15:0]) : XLEN'($signed(v[15:0]));
      2'd2:    x = uns ? XLEN'(v[31:0]) : XLEN'($signed(v[31:0]));
      default: x = v;
    endcase
    return x;
  endfunction

  // Lane placement of the incoming request (double-width when splitting is possible).
  always_comb begin
    in_off = req_addr[OFFW-1:0];
    strb_w = '0;
    for (int i = 0; i < LW*NBYTES; i++) strb_w[i] = (i < (1 << req_size));
    strb_w  = strb_w << in_off;
    wdata_w = (LW*XLEN)'(req_wdata) << {in_off, 3'b000};
    case (req_size)
      2'd0:    amask = 3'd0;
      2'd1:    amask = 3'd1;
      2'd2:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
    mis     = |(req_addr[2:0] & amask);
    illegal = (XLEN == 32) && (req_size == 2'd3);
  end

  always_comb begin
`ifdef CPU_LSU_SPLIT_EN
    merged = hi_phase ? {mem_rdata, lo_q} : (LW*XLEN)'(mem_rdata);
`else
    merged = mem_rdata;
`endif
    merged = merged >> {r.off, 3'b000};
    field  = merged[XLEN-1:0];
  end

  // Watchdog fires after TIMEOUT whole cycles in REQ/WAIT without progress.
  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    abort     = 1'b0;
    done_beat = 1'b0;
    if (state == IDLE) begin
      if (req_valid) begin
        accept  = 1'b1;
        state_n = bad ? RESP : REQ;
      end
    end else if (state == RESP) begin
      state_n = IDLE;
    end else begin
      done_beat = in_req ? (mem_ready && (r.store || mem_rvalid)) : (in_wait && mem_rvalid);
      if (done_beat) begin
`ifdef CPU_LSU_SPLIT_EN
        state_n = last ? RESP : REQ2;
`else
        state_n = RESP;
`endif
      end else if (in_req && mem_ready) begin
`ifdef CPU_LSU_SPLIT_EN
        state_n = hi_phase ? WAIT2 : WAIT;
`else
        state_n = WAIT;
`endif
      end else if (wd_hit) begin
        abort   = 1'b1;
        state_n = RESP;
      end
    end
  end

  assign capture = done_beat && last && !r.store;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      r           <= '0;
      wd_cnt      <= '0;
      mem_addr_q  <= '0;
      mem_write_q <= '0;
      mem_wdata_q <= '0;
      resp_data_q <= '0;
      resp_rd_q   <= '0;
      fault_q     <= 1'b0;
`ifdef CPU_LSU_SPLIT_EN
      hi_strb_q   <= '0;
      hi_wdata_q  <= '0;
      lo_q        <= '0;
      split_q     <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      wd_cnt <= (state_n != state) ? 16'd0 : wd_cnt + 16'd1;
      if (accept) begin
        r           <= '{store: req_store, size: req_size, uns: req_unsigned, off: in_off};
        mem_addr_q  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        mem_write_q <= (req_store && !bad) ? strb_w[NBYTES-1:0] : '0;
        mem_wdata_q <= wdata_w[XLEN-1:0];
        resp_data_q <= '0;
        resp_rd_q   <= req_store ? 5'd0 : req_rd;
        fault_q     <= bad;
`ifdef CPU_LSU_SPLIT_EN
        hi_strb_q   <= req_store ? strb_w[LW*NBYTES-1:NBYTES] : '0;
        hi_wdata_q  <= wdata_w[LW*XLEN-1:XLEN];
        split_q     <= |strb_w[LW*NBYTES-1:NBYTES] && !bad;
`endif
      end
      if ((in_req && mem_ready) || abort) mem_write_q <= '0;
`ifdef CPU_LSU_SPLIT_EN
      if (capture_lo) lo_q <= mem_rdata;
      if (done_beat && !last) begin
        mem_addr_q  <= mem_addr_q + XLEN'(NBYTES);
        mem_write_q <= hi_strb_q;
        mem_wdata_q <= hi_wdata_q;
      end
`endif
      if (capture) resp_data_q <= extend(field, r.size, r.uns);
      if (abort)   fault_q     <= 1'b1;
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign mem_valid  = in_req;
  assign mem_addr   = mem_addr_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = (state == RESP);
  assign fault      = (state == RESP) && fault_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;
endmodule

// File: tb/tb_cpu_lsu.sv
// Directed bench for cpu_lsu: XLEN=32 with an 8-cycle watchdog, plus an XLEN=64 instance for ld/lw/lwu/sd.
module tb_cpu_lsu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_store, req_unsigned, mem_ready, mem_rvalid;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [4:0]  req_rd;
  logic        req_ready, mem_valid, resp_valid, fault, busy;
  logic [31:0] mem_addr, mem_wdata, resp_data;
  logic [3:0]  mem_write;
  logic [4:0]  resp_rd;

  logic        req_valid6, req_store6, req_unsigned6, mem_ready6, mem_rvalid6;
  logic [1:0]  req_size6;
  logic [63:0] req_addr6, req_wdata6, mem_rdata6;
  logic [4:0]  req_rd6;
  logic        req_ready6, mem_valid6, resp_valid6, fault6, busy6;
  logic [63:0] mem_addr6, mem_wdata6, resp_data6;
  logic [7:0]  mem_write6;
  logic [4:0]  resp_rd6;

  int tests = 0;
  int fails = 0;

  cpu_lsu #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data), .fault(fault), .busy(busy));

  cpu_lsu #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .req_valid(req_valid6), .req_ready(req_ready6), .req_store(req_store6),
    .req_size(req_size6), .req_unsigned(req_unsigned6), .req_addr(req_addr6), .req_wdata(req_wdata6),
    .req_rd(req_rd6), .mem_valid(mem_valid6), .mem_ready(mem_ready6), .mem_addr(mem_addr6),
    .mem_write(mem_write6), .mem_wdata(mem_wdata6), .mem_rvalid(mem_rvalid6), .mem_rdata(mem_rdata6),
    .resp_valid(resp_valid6), .resp_rd(resp_rd6), .resp_data(resp_data6), .fault(fault6), .busy(busy6));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Present one request to the 32-bit DUT; returns just after the accepting edge.
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_rd = rd;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic issue64(input logic st, input logic [1:0] sz, input logic uns, input logic [63:0] a,
                         input logic [63:0] wd, input logic [4:0] rd);
    req_valid6 = 1'b1; req_store6 = st; req_size6 = sz; req_unsigned6 = uns;
    req_addr6 = a; req_wdata6 = wd; req_rd6 = rd;
    cyc();
    req_valid6 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    logic done;
    reset = 1'b1;
    req_valid = 0; req_store = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    req_valid6 = 0; req_store6 = 0; req_size6 = 0; req_unsigned6 = 0; req_addr6 = 0; req_wdata6 = 0;
    req_rd6 = 0; mem_ready6 = 1; mem_rvalid6 = 1; mem_rdata6 = 0;
    repeat (2) cyc();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_req_ready", req_ready, 1);
    reset = 1'b0;
    cyc();

    // sw 0xDEADBEEF @0x100, bus ready immediately
    mem_ready = 1'b1;
    issue(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 5'd7);
    chk("sw_mem_valid", mem_valid, 1);
    chk("sw_req_ready", req_ready, 0);
    chk("sw_mem_addr", mem_addr, 32'h100);
    chk("sw_strobe", mem_write, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    cyc();
    chk("sw_resp_valid", resp_valid, 1);
    chk("sw_fault", fault, 0);
    chk("sw_resp_rd", resp_rd, 0);
    cyc();
    chk("sw_resp_pulse", resp_valid, 0);

    // lb @0x103, data one cycle after the request handshake
    mem_rdata = 32'h80123456;
    issue(0, 2'd0, 0, 32'h103, 32'h0, 5'd9);
    chk("lb_mem_addr", mem_addr, 32'h100);
    chk("lb_strobe", mem_write, 4'b0000);
    cyc();
    chk("lb_wait_no_resp", resp_valid, 0);
    mem_rvalid = 1'b1;
    cyc();
    mem_rvalid = 1'b0;
    chk("lb_resp_valid", resp_valid, 1);
    chk("lb_data", resp_data, 32'hFFFFFF80);
    chk("lb_rd", resp_rd, 5'd9);
    cyc();

    // lbu @0x103 with rvalid alongside mem_ready: completes in 2 cycles
    mem_rvalid = 1'b1;
    issue(0, 2'd0, 1, 32'h103, 32'h0, 5'd10);
    cyc();
    mem_rvalid = 1'b0;
    chk("lbu_resp_valid", resp_valid, 1);
    chk("lbu_data", resp_data, 32'h00000080);
    cyc();

    // lhu @0x106 -> upper half of the word
    mem_rdata = 32'hFEDC0000;
    mem_rvalid = 1'b1;
    issue(0, 2'd1, 1, 32'h106, 32'h0, 5'd11);
    chk("lhu_mem_addr", mem_addr, 32'h104);
    cyc();
    mem_rvalid = 1'b0;
    chk("lhu_data", resp_data, 32'h0000FEDC);
    cyc();

    // sh @0x102
    issue(1, 2'd1, 0, 32'h102, 32'hCAFE1234, 5'd3);
    chk("sh_strobe", mem_write, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'h12340000);
    cyc();
    chk("sh_resp_valid", resp_valid, 1);
    cyc();

    // lw @0x102 misaligned: no bus cycle, immediate faulting response
    issue(0, 2'd2, 0, 32'h102, 32'h0, 5'd4);
    chk("mis_mem_valid", mem_valid, 0);
    chk("mis_resp_valid", resp_valid, 1);
    chk("mis_fault", fault, 1);
    cyc();
    chk("mis_idle", busy, 0);

    // size 3 is illegal at XLEN=32
    issue(0, 2'd3, 0, 32'h100, 32'h0, 5'd4);
    chk("sd32_mem_valid", mem_valid, 0);
    chk("sd32_fault", fault, 1);
    cyc();

    // watchdog: bus never ready
    mem_ready = 1'b0;
    issue(0, 2'd2, 0, 32'h300, 32'h0, 5'd5);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (resp_valid) done = 1'b1;
      else begin
        if (mem_valid) n++;
        cyc();
      end
    end
    chk("to_resp_seen", done, 1);
    chk("to_req_cycles", n, 8);
    chk("to_fault", fault, 1);
    cyc();
    mem_rvalid = 1'b1;
    cyc();
    mem_rvalid = 1'b0;
    chk("late_rvalid_busy", busy, 0);
    chk("late_rvalid_resp", resp_valid, 0);
    mem_ready = 1'b1;
    issue(1, 2'd2, 0, 32'h104, 32'h01020304, 5'd0);
    cyc();
    chk("after_to_resp", resp_valid, 1);
    chk("after_to_fault", fault, 0);
    cyc();

    // asynchronous reset while waiting for read data
    issue(0, 2'd2, 0, 32'h200, 32'h0, 5'd6);
    cyc();
    chk("wait_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_req_ready", req_ready, 1);
    cyc();
    reset = 1'b0;
    mem_rvalid = 1'b1;
    cyc();
    mem_rvalid = 1'b0;
    chk("arst_no_resp", resp_valid, 0);

    // XLEN=64: ld, lw, lwu, sd (bus ready and rvalid held high)
    mem_rdata6 = 64'h8000000000000001;
    issue64(0, 2'd3, 1, 64'h108, 64'h0, 5'd12);
    chk("ld_mem_addr", mem_addr6, 64'h108);
    cyc();
    chk("ld_data", resp_data6, 64'h8000000000000001);
    cyc();
    mem_rdata6 = 64'h87654321_00000000;
    issue64(0, 2'd2, 0, 64'h10C, 64'h0, 5'd13);
    cyc();
    chk("lw64_data", resp_data6, 64'hFFFFFFFF87654321);
    cyc();
    issue64(0, 2'd2, 1, 64'h10C, 64'h0, 5'd13);
    cyc();
    chk("lwu64_data", resp_data6, 64'h0000000087654321);
    cyc();
    issue64(1, 2'd3, 0, 64'h110, 64'h1122334455667788, 5'd0);
    chk("sd64_strobe", mem_write6, 8'hFF);
    chk("sd64_wdata", mem_wdata6, 64'h1122334455667788);
    cyc();
    chk("sd64_fault", fault6, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
